// File: rtl/uart_tx_sched.sv
// UART TX scheduler: arbitrates core and sID byte producers into a small TX FIFO and
// drains it as single-cycle register writes to the UART, paced by the UART busy flag.

`ifndef UART_TX_ADDR
`define UART_TX_ADDR 32'h0000_1000
`endif

module uart_tx_sched #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] TX_ADDR    = `UART_TX_ADDR,
    parameter int          BUSY_TMO   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req_i,
    input  logic [7:0]  core_data_i,
    output logic        core_gnt_o,
    input  logic        sid_req_i,
    input  logic        sid_lock_i,
    input  logic [7:0]  sid_data_i,
    output logic        sid_gnt_o,
    input  logic        uart_busy_i,
    output logic        uart_we_o,
    output logic [31:0] uart_waddr_o,
    output logic [31:0] uart_wdata_o,
    output logic        fifo_full_o,
    output logic        idle_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TMO) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_WAIT_RISE = 2'd2,
        ST_WAIT_FALL = 2'd3
    } state_t;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          owner_sid_r;
    logic          last_sid_r;
    state_t        state_r;
    logic [TW-1:0] tmo_r;

    logic          full_s;
    logic          empty_s;
    logic          core_gnt_s;
    logic          sid_gnt_s;
    logic          push_s;
    logic          pop_s;
    logic [7:0]    push_data_s;

    assign full_s      = (count_r == CW'(FIFO_DEPTH));
    assign empty_s     = (count_r == {CW{1'b0}});
    assign push_s      = core_gnt_s | sid_gnt_s;
    assign push_data_s = sid_gnt_s ? sid_data_i : core_data_i;
    assign pop_s       = (state_r == ST_IDLE) && !empty_s && !uart_busy_i;

    // Grant decision: locked sID excludes core, otherwise round-robin on ties
    always_comb begin
        core_gnt_s = 1'b0;
        sid_gnt_s  = 1'b0;
        if (rst || full_s) begin
            core_gnt_s = 1'b0;
            sid_gnt_s  = 1'b0;
        end else if (owner_sid_r) begin
            sid_gnt_s = sid_req_i;
        end else if (core_req_i && sid_req_i) begin
            core_gnt_s = last_sid_r;
            sid_gnt_s  = ~last_sid_r;
        end else begin
            core_gnt_s = core_req_i;
            sid_gnt_s  = sid_req_i;
        end
    end

    // Ownership and round-robin history; last_sid_r starts set so core wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_sid_r <= 1'b0;
            last_sid_r  <= 1'b1;
        end else begin
            if (!sid_lock_i) begin
                owner_sid_r <= 1'b0;
            end else if (sid_gnt_s) begin
                owner_sid_r <= 1'b1;
            end else begin
                owner_sid_r <= owner_sid_r;
            end
            if (push_s) begin
                last_sid_r <= sid_gnt_s;
            end else begin
                last_sid_r <= last_sid_r;
            end
        end
    end

    // TX FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Drain FSM; the write bus registers double as the popped byte holder
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            tmo_r        <= {TW{1'b0}};
            uart_we_o    <= 1'b0;
            uart_waddr_o <= 32'h0000_0000;
            uart_wdata_o <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_r      <= ST_WRITE;
                        uart_we_o    <= 1'b1;
                        uart_waddr_o <= TX_ADDR;
                        uart_wdata_o <= {24'h00_0000, mem_r[rd_ptr_r]};
                    end
                end
                ST_WRITE: begin
                    state_r      <= ST_WAIT_RISE;
                    tmo_r        <= {TW{1'b0}};
                    uart_we_o    <= 1'b0;
                    uart_waddr_o <= 32'h0000_0000;
                    uart_wdata_o <= 32'h0000_0000;
                end
                ST_WAIT_RISE: begin
                    // A missing busy pulse means the write was lost or already done; no retry
                    if (uart_busy_i) begin
                        state_r <= ST_WAIT_FALL;
                    end else if (tmo_r == TMO_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                    end
                end
                ST_WAIT_FALL: begin
                    if (!uart_busy_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    uart_we_o    <= 1'b0;
                    uart_waddr_o <= 32'h0000_0000;
                    uart_wdata_o <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign core_gnt_o  = core_gnt_s;
    assign sid_gnt_o   = sid_gnt_s;
    assign fifo_full_o = full_s;
    assign idle_o      = empty_s && (state_r == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed producer traffic, a small UART busy model,
// and a monitor that pops expected writes as the DUT strobes uart_we.

module tb_uart_tx_sched;

    localparam logic [31:0] ADDR = 32'h0000_A004;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic [7:0]  core_data;
    logic        core_gnt;
    logic        sid_req;
    logic        sid_lock;
    logic [7:0]  sid_data;
    logic        sid_gnt;
    logic        uart_busy = 1'b0;
    logic        uart_we;
    logic [31:0] uart_waddr;
    logic [31:0] uart_wdata;
    logic        fifo_full;
    logic        idle;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_wr = 0;
    int          core_gnt_cyc = 0;
    int          busy_len = 5;
    int          busy_cnt = 0;
    bit          busy_force = 1'b0;
    bit          busy_dead = 1'b0;
    bit          mon_en = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;
    int          wr_cyc_q[$];
    logic        src_log[$];

    always #5 clk = ~clk;

    uart_tx_sched #(.FIFO_DEPTH(8), .TX_ADDR(ADDR), .BUSY_TMO(4)) dut (
        .clk(clk), .rst(rst),
        .core_req_i(core_req), .core_data_i(core_data), .core_gnt_o(core_gnt),
        .sid_req_i(sid_req), .sid_lock_i(sid_lock), .sid_data_i(sid_data), .sid_gnt_o(sid_gnt),
        .uart_busy_i(uart_busy), .uart_we_o(uart_we), .uart_waddr_o(uart_waddr),
        .uart_wdata_o(uart_wdata), .fifo_full_o(fifo_full), .idle_o(idle)
    );

    task automatic check32(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back({ADDR, 24'h00_0000, s[i]});
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy rises with the write strobe and stays up for busy_len cycles
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busy_cnt = 0;
            end else if (uart_we === 1'b1) begin
                check32("we_while_busy", busy_cnt, 0);
                if (!busy_dead) busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            uart_busy = busy_force || (busy_cnt != 0);
        end
    end

    // Monitor: every write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (uart_we === 1'b1) begin
                n_wr++;
                wr_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write: got %h, want no write", {uart_waddr, uart_wdata});
                end else begin
                    exp_e = exp_q.pop_front();
                    check64("write", {uart_waddr, uart_wdata}, exp_e);
                end
            end else begin
                check64("bus_quiet", {uart_waddr, uart_wdata}, 64'h0);
            end
        end
    end

    task automatic core_send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            int n;
            bit got;
            n = 0;
            got = 1'b0;
            core_req = 1'b1;
            core_data = s[i];
            while (!got && n < 400) begin
                @(negedge clk);
                got = core_gnt;
                if (got) begin
                    src_log.push_back(1'b0);
                    core_gnt_cyc = cyc;
                end
                @(posedge clk);
                #1;
                n++;
            end
            if (!got) begin
                n_vec++;
                n_bad++;
                $display("FAIL core_grant_timeout: got no grant for %h, want grant", s[i]);
            end
        end
        core_req = 1'b0;
    endtask

    task automatic sid_send(input string s, input logic lock);
        sid_lock = lock;
        for (int i = 0; i < s.len(); i++) begin
            int n;
            bit got;
            n = 0;
            got = 1'b0;
            sid_req = 1'b1;
            sid_data = s[i];
            while (!got && n < 400) begin
                @(negedge clk);
                got = sid_gnt;
                if (got) src_log.push_back(1'b1);
                @(posedge clk);
                #1;
                n++;
            end
            if (!got) begin
                n_vec++;
                n_bad++;
                $display("FAIL sid_grant_timeout: got no grant for %h, want grant", s[i]);
            end
        end
        sid_req = 1'b0;
        sid_lock = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        core_req = 1'b0;
        sid_req = 1'b0;
        sid_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        src_log.delete();
        wr_cyc_q.delete();
        n_wr = 0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(idle && !uart_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_drain_timeout: got not idle, want idle", name);
        end
        check32({name, "_pending"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        core_req = 1'b0;
        core_data = 8'h00;
        sid_req = 1'b0;
        sid_lock = 1'b0;
        sid_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_we", int'(uart_we), 0);
        check64("rst_bus", {uart_waddr, uart_wdata}, 64'h0);
        check32("rst_full", int'(fifo_full), 0);
        check32("rst_idle", int'(idle), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Single core byte: one write, two cycles after grant
        do_reset();
        busy_len = 20;
        expect_str("A");
        core_send("A");
        drain("t1");
        check32("t1_writes", n_wr, 1);
        lat = (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - core_gnt_cyc : -1;
        check32("t1_latency", lat, 2);

        // Both requesting every cycle: alternate, core first
        do_reset();
        busy_len = 3;
        expect_str("AaBbCcDd");
        fork
            core_send("ABCD");
            sid_send("abcd", 1'b0);
        join
        drain("t2");
        check32("t2_grants", src_log.size(), 8);
        for (int i = 0; i < 8 && i < src_log.size(); i++) begin
            check32("t2_grant_src", int'(src_log[i]), i % 2);
        end

        // Locked sID burst keeps core out until lock drops
        do_reset();
        busy_len = 5;
        expect_str("2023310655C");
        fork
            sid_send("2023310655", 1'b1);
            begin
                @(posedge clk);
                #1;
                core_send("C");
            end
        join
        drain("t3");
        check32("t3_grants", src_log.size(), 11);
        if (src_log.size() == 11) check32("t3_last_src", int'(src_log[10]), 0);

        // Fill FIFO with busy stuck high, then release
        busy_force = 1'b1;
        do_reset();
        busy_len = 3;
        expect_str("01234567zZ");
        core_send("01234567");
        core_req = 1'b1;
        core_data = 8'h5A;
        sid_req = 1'b1;
        sid_data = 8'h7A;
        @(negedge clk);
        check32("t4_full", int'(fifo_full), 1);
        check32("t4_gnts_full", int'({core_gnt, sid_gnt}), 0);
        busy_force = 1'b0;
        @(negedge clk);
        check32("t4_still_full", int'(fifo_full), 1);
        check32("t4_gnts_wait", int'({core_gnt, sid_gnt}), 0);
        @(negedge clk);
        check32("t4_full_drop", int'(fifo_full), 0);
        check32("t4_gnts_resume", int'({core_gnt, sid_gnt}), 1);
        @(posedge clk);
        #1;
        sid_req = 1'b0;
        begin
            int n;
            bit got;
            n = 0;
            got = 1'b0;
            while (!got && n < 400) begin
                @(negedge clk);
                got = core_gnt;
                @(posedge clk);
                #1;
                n++;
            end
            check32("t4_core_granted", int'(got), 1);
        end
        core_req = 1'b0;
        drain("t4");

        // Busy never rises: timeout after BUSY_TMO cycles, next byte still written
        do_reset();
        busy_dead = 1'b1;
        expect_str("PQ");
        core_send("PQ");
        drain("t5");
        busy_dead = 1'b0;
        check32("t5_writes", wr_cyc_q.size(), 2);
        lat = (wr_cyc_q.size() == 2) ? wr_cyc_q[1] - wr_cyc_q[0] : -1;
        check32("t5_gap", lat, 6);

        // Reset in WAIT_FALL with three bytes queued drops them
        do_reset();
        busy_len = 30;
        expect_str("W");
        core_send("WXYZ");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check32("t6_idle", int'(idle), 1);
        check32("t6_we", int'(uart_we), 0);
        drain("t6");
        repeat (20) @(posedge clk);
        #1;
        check32("t6_writes", n_wr, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

endmodule
